// File: rtl/trdb_branch_map.sv
// rtl/trdb_branch_map.sv - retired conditional branch outcome bit map
//
// Purpose:
//   Records the taken/not-taken outcome of each retired conditional branch
//   into a bit map, in retirement order, for the packet priority stage.
//   The map is cleared by flush_i when a packet carrying it is emitted.
//   During the flush cycle the outputs still show the pre-flush contents,
//   so the emitter samples them in the same cycle as flush_i.
//
// Optional feature macro: TRDB_BRANCH_MAP_OVERFLOW_EN
//   defined   - a write into a full map sets a sticky overflow register,
//               cleared only by flush_i or reset; a simulation assertion
//               reports the event.
//   undefined - a write into a full map is silently dropped and
//               overflow_o is tied to 0.
//
// Parameters:
//   NUM_BRANCHES - map capacity in branches (1..XLEN), default 31
//   CNT_W        - branch counter width, $clog2(NUM_BRANCHES+1)
//
// Ports:
//   clk_i          in   clock
//   rst_ni         in   asynchronous active-low reset
//   valid_i        in   retired instruction qualified for tracing
//   branch_i       in   retired instruction is a conditional branch
//   branch_taken_i in   branch outcome, 1 = taken
//   flush_i        in   map is being emitted this cycle; clear it
//   map_o          out  bit i = i-th recorded branch, 1 = NOT taken
//   branches_o     out  number of valid bits in map_o
//   is_full_o      out  branches_o == NUM_BRANCHES
//   is_empty_o     out  branches_o == 0
//   overflow_o     out  sticky overflow flag

module trdb_branch_map #(
    parameter int unsigned NUM_BRANCHES = 31,
    parameter int unsigned CNT_W        = $clog2(NUM_BRANCHES + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    valid_i,
    input  logic                    branch_i,
    input  logic                    branch_taken_i,
    input  logic                    flush_i,
    output logic [NUM_BRANCHES-1:0] map_o,
    output logic [CNT_W-1:0]        branches_o,
    output logic                    is_full_o,
    output logic                    is_empty_o,
    output logic                    overflow_o
);

    logic [NUM_BRANCHES-1:0] r_map;
    logic [CNT_W-1:0]        r_count;

    logic                    w_wr;
    logic                    w_full;
    logic                    w_empty;
    logic [NUM_BRANCHES-1:0] w_map_nxt;
    logic [CNT_W-1:0]        w_count_nxt;

    assign w_wr    = valid_i & branch_i;
    assign w_full  = (r_count == CNT_W'(NUM_BRANCHES));
    assign w_empty = (r_count == '0);

    // Next-state rules in priority order: flush (optionally restarting the
    // map with the incoming branch), append, then hold. A write into a full
    // map falls through to hold, which is what drops it.
    always_comb begin
        w_map_nxt   = r_map;
        w_count_nxt = r_count;
        if (flush_i) begin
            w_map_nxt   = '0;
            w_count_nxt = '0;
            if (w_wr) begin
                w_map_nxt[0] = ~branch_taken_i;
                w_count_nxt  = CNT_W'(1);
            end
        end else if (w_wr && !w_full) begin
            // Bit selection by compare keeps the write index in range for
            // any NUM_BRANCHES; bits above the count remain 0.
            for (int i = 0; i < int'(NUM_BRANCHES); i++) begin
                if (CNT_W'(i) == r_count) begin
                    w_map_nxt[i] = ~branch_taken_i;
                end
            end
            w_count_nxt = r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_map   <= '0;
            r_count <= '0;
        end else begin
            r_map   <= w_map_nxt;
            r_count <= w_count_nxt;
        end
    end

`ifdef TRDB_BRANCH_MAP_OVERFLOW_EN
    logic r_overflow;
    logic w_overflow_evt;

    // Flush has priority, so an overflow can only happen without flush_i.
    assign w_overflow_evt = w_wr & ~flush_i & w_full;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overflow <= 1'b0;
        end else if (flush_i) begin
            r_overflow <= 1'b0;
        end else if (w_overflow_evt) begin
            r_overflow <= 1'b1;
        end
    end

    // The priority stage should flush while the map is full; a write into
    // a full map means a branch outcome has been lost.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!w_overflow_evt)
                else $warning("trdb_branch_map: branch dropped, map full");
        end
    end

    assign overflow_o = r_overflow;
`else
    assign overflow_o = 1'b0;
`endif

    assign map_o      = r_map;
    assign branches_o = r_count;
    assign is_full_o  = w_full;
    assign is_empty_o = w_empty;

endmodule

// File: tb/tb_trdb_branch_map.sv
// tb/tb_trdb_branch_map.sv - directed self-checking bench for trdb_branch_map

module tb_trdb_branch_map;

    localparam int NB = 31;
    localparam int CW = $clog2(NB + 1);

    logic          clk;
    logic          rst_n;
    logic          valid;
    logic          branch;
    logic          taken;
    logic          flush;
    logic [NB-1:0] map;
    logic [CW-1:0] branches;
    logic          full;
    logic          empty;
    logic          overflow;

    int n_pass  = 0;
    int n_total = 0;

`ifdef TRDB_BRANCH_MAP_OVERFLOW_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    trdb_branch_map #(
        .NUM_BRANCHES(NB)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .valid_i       (valid),
        .branch_i      (branch),
        .branch_taken_i(taken),
        .flush_i       (flush),
        .map_o         (map),
        .branches_o    (branches),
        .is_full_o     (full),
        .is_empty_o    (empty),
        .overflow_o    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic b, input logic t, input logic f);
        valid  = v;
        branch = b;
        taken  = t;
        flush  = f;
    endtask

    // Applies inputs for one clock edge and returns 1 time unit after it.
    task automatic cyc(input logic v, input logic b, input logic t, input logic f);
        drive(v, b, t, f);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_map"},   map,                   32'h0);
        chk({tag, "_cnt"},   32'(branches),         32'd0);
        chk({tag, "_empty"}, {31'd0, empty},        32'd1);
        chk({tag, "_full"},  {31'd0, full},         32'd0);
        chk({tag, "_ovf"},   {31'd0, overflow},     32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset("rst");
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk_reset("idle");

        // taken, not-taken, not-taken -> map 0b110
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("first_cnt", 32'(branches), 32'd1);
        chk("first_map", 32'(map),      32'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("three_map",   32'(map),      32'h6);
        chk("three_cnt",   32'(branches), 32'd3);
        chk("three_empty", {31'd0, empty}, 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("hold_map", 32'(map),      32'h6);
        chk("hold_cnt", 32'(branches), 32'd3);

        // plain flush: pre-flush contents visible during the flush cycle
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("fl_pre_map", 32'(map), 32'h6);
        @(posedge clk);
        #1;
        chk("fl_post_cnt",   32'(branches), 32'd0);
        chk("fl_post_map",   32'(map),      32'h0);
        chk("fl_post_empty", {31'd0, empty}, 32'd1);

        // fill with 31 not-taken branches
        for (int i = 0; i < NB; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("full_cnt",   32'(branches), 32'd31);
        chk("full_map",   32'(map),      32'h7FFF_FFFF);
        chk("full_flag",  {31'd0, full}, 32'd1);
        chk("full_empty", {31'd0, empty}, 32'd0);

        // flush together with a taken write starts a new map
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        chk("flw_pre_map", 32'(map),      32'h7FFF_FFFF);
        chk("flw_pre_cnt", 32'(branches), 32'd31);
        @(posedge clk);
        #1;
        chk("flw_post_map",  32'(map),      32'h0);
        chk("flw_post_cnt",  32'(branches), 32'd1);
        chk("flw_post_full", {31'd0, full}, 32'd0);

        // refill (30 more not-taken), then write without flush
        for (int i = 0; i < NB - 1; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("refill_cnt", 32'(branches), 32'd31);
        chk("refill_map", 32'(map),      32'h7FFF_FFFE);
        chk("refill_ovf", {31'd0, overflow}, 32'd0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("ovf_map",  32'(map),      32'h7FFF_FFFE);
        chk("ovf_cnt",  32'(branches), 32'd31);
        chk("ovf_flag", {31'd0, overflow}, {31'd0, OVF_EXP});
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovf_sticky", {31'd0, overflow}, {31'd0, OVF_EXP});
        chk("ovf_full",   {31'd0, full},     32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr_flag", {31'd0, overflow}, 32'd0);
        chk("ovf_clr_cnt",  32'(branches),     32'd0);

        // five writes T,N,T,N,T -> bits 0,1,0,1,0 = 0xA, then async reset
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("five_map", 32'(map),      32'hA);
        chk("five_cnt", 32'(branches), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async_rst");
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // non-writes: valid without branch, branch without valid
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, i[0], 1'b0);
            chk("nv_cnt",   32'(branches), 32'd0);
            chk("nv_empty", {31'd0, empty}, 32'd1);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, i[0], 1'b0);
            chk("nb_cnt",   32'(branches), 32'd0);
            chk("nb_empty", {31'd0, empty}, 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/trdb_branch_map.md
Name: trdb_branch_map

Overview:
- Upstream neighbour of the packet priority stage. Records the taken/not-taken outcome of each retired conditional branch into a bit map, in retirement order.
- Drives the branch_map_full / branch_map_empty flags that the priority stage consumes.
- Provides the map contents and the branch count for packet assembly.
- The map is cleared by a flush when a packet carrying the map is emitted.

Parameters:
- NUM_BRANCHES, 31, capacity of the map in branches; legal range 1..XLEN.
- CNT_W, $clog2(NUM_BRANCHES+1), width of the branch counter (5 for default).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  retired instruction qualified for tracing this cycle.
- branch_i  input  1  retired instruction is a conditional branch.
- branch_taken_i  input  1  branch outcome, 1 = taken.
- flush_i  input  1  packet containing the map is emitted this cycle; clear the map.
- map_o  output  NUM_BRANCHES  branch bits; bit i = i-th recorded branch; 1 = NOT taken, 0 = taken.
- branches_o  output  CNT_W  number of valid bits in map_o.
- is_full_o  output  1  branches_o == NUM_BRANCHES.
- is_empty_o  output  1  branches_o == 0.
- overflow_o  output  1  sticky overflow flag (see Optional Feature).

Behaviour:
- Reset (async, rst_ni low): map register = 0, count = 0, overflow = 0. Consequently map_o=0, branches_o=0, is_full_o=0, is_empty_o=1, overflow_o=0. Reset asserted mid-operation discards all contents immediately.
- Write condition: wr = valid_i & branch_i. branch_taken_i is ignored when wr = 0.
- Outputs are driven directly from registers. is_full_o and is_empty_o are combinational compares on the count register. Zero-cycle flag latency with respect to register state.
- A recorded branch is visible on map_o, branches_o and the flags one cycle after wr.
- Next-state rules, evaluated at each rising edge in priority order:
  1. flush_i & wr: map = 0 except bit0 = ~branch_taken_i; count = 1. The incoming branch starts the new map.
  2. flush_i & ~wr: map = 0; count = 0.
  3. ~flush_i & wr & count < NUM_BRANCHES: map[count] = ~branch_taken_i; count = count + 1; all other bits hold.
  4. ~flush_i & wr & count == NUM_BRANCHES: overflow; the write is dropped and map/count hold. The overflow flag is handled per the Optional Feature.
  5. Otherwise: hold.
- During a flush cycle, map_o and branches_o still present the pre-flush contents, so the emitter samples them in the same cycle as flush_i.
- Bits at index >= count are always 0. The counter never wraps and never exceeds NUM_BRANCHES.
- Intended system usage: the priority stage raises a full-map packet while is_full_o = 1 and asserts flush_i in that cycle, so rule 4 is an error path only.
- valid_i = 0 with branch_i = 1 records nothing.

Optional Feature:
- Macro TRDB_BRANCH_MAP_OVERFLOW_EN.
- Defined:
  - Rule 4 sets an overflow register; overflow_o stays 1 until flush_i or reset.
  - Flush with a simultaneous overflow condition cannot occur, because flush takes priority.
  - An assertion fires on rule 4 in simulation.
- Undefined:
  - No overflow register; overflow_o is tied to 0.
  - Rule 4 silently drops the branch.

Test Plan:
- Reset then idle -> map_o=0, branches_o=0, is_empty_o=1, is_full_o=0, overflow_o=0.
- Three writes (taken, not-taken, not-taken) on consecutive cycles -> one cycle after the last: map_o=0b110, branches_o=3, is_empty_o=0.
- 31 not-taken writes -> branches_o=31, map_o=0x7FFF_FFFF, is_full_o=1.
  - Next cycle: flush_i together with a taken write -> during the flush cycle map_o is still 0x7FFF_FFFF; the cycle after, map_o=0, branches_o=1.
- Full map, then a write without flush_i -> map/count unchanged.
  - Macro defined: overflow_o=1 and stays 1 until flush_i, after which overflow_o=0 and branches_o=0.
  - Macro undefined: overflow_o=0.
- Five writes, then rst_ni pulsed low asynchronously mid-cycle -> outputs return to reset values before the next edge.
- valid_i=0 with branch_i=1, and valid_i=1 with branch_i=0, for 10 cycles each -> branches_o stays 0 and is_empty_o stays 1.
